// File: rtl/ps2_kbd_if.sv
// CPU-side I/O port of the PS/2 keyboard controller: strobes, register select,
// data buses and the interrupt line.
interface ps2_kbd_if;
    logic       cs;
    logic       rs;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       n_int;

    modport master (
        output cs, rs, rd_n, wr_n, data_in,
        input  data_out, n_int
    );

    modport slave (
        input  cs, rs, rd_n, wr_n, data_in,
        output data_out, n_int
    );
endinterface

// File: rtl/ps2_kbd.sv
// PS/2 keyboard receiver with scan-code FIFO, status/control register and
// level interrupt, on the single clk_cpu domain.
//   state  | meaning
//   IDLE   | waiting for a start bit (data low on a ps2 clock fall)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | capturing the odd-parity bit
//   STOP   | capturing the stop bit, then judging the frame
module ps2_kbd #(
    parameter int c_fifo_bits = 3,
    parameter int c_timeout   = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_kbd_if.slave bus
);
    localparam int to_bits  = $clog2(c_timeout + 1);
    localparam int depth    = 2 ** c_fifo_bits;
    localparam logic [c_fifo_bits:0] ptr_one = 1;
    localparam logic [to_bits-1:0]   to_max  = to_bits'(c_timeout);
    localparam logic [to_bits-1:0]   to_one  = 1;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    logic [1:0]          clk_sync;
    logic [1:0]          data_sync;
    logic                clk_dly;
    logic                ps2_fall;
    logic                data_s;

    rx_state_t           state;
    logic [7:0]          shift;
    logic [2:0]          bit_cnt;
    logic                par_bit;
    logic [to_bits-1:0]  to_cnt;
    logic                push_req;
    logic                frame_err;

    logic [7:0]          mem [depth];
    logic [c_fifo_bits:0] wr_ptr;
    logic [c_fifo_bits:0] rd_ptr;
    logic                empty;
    logic                full;

    logic                rd_act, wr_act, rd_q, wr_q, rd_stb, wr_stb;
    logic                pop, flush, push_ok;
    logic                ovr, perr, ien, n_int_q;
    logic [7:0]          status;
    logic [7:0]          dout;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
            clk_dly   <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
            clk_dly   <= clk_sync[1];
        end
    end

    assign ps2_fall = clk_dly & ~clk_sync[1];
    assign data_s   = data_sync[1];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= IDLE;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            push_req  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            push_req  <= 1'b0;
            frame_err <= 1'b0;
            if (state == IDLE || ps2_fall)
                to_cnt <= '0;
            else if (to_cnt != to_max)
                to_cnt <= to_cnt + to_one;

            // a stalled keyboard drops the partial frame silently
            if (state != IDLE && !ps2_fall && to_cnt == to_max) begin
                state   <= IDLE;
                shift   <= 8'h00;
                bit_cnt <= 3'd0;
            end else if (ps2_fall) begin
                case (state)
                    IDLE: begin
                        if (!data_s) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= data_s;
                        state   <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if ((^{shift, par_bit}) && data_s)
                            push_req <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[c_fifo_bits-1:0] == rd_ptr[c_fifo_bits-1:0]) &&
                   (wr_ptr[c_fifo_bits] != rd_ptr[c_fifo_bits]);

    assign rd_act  = bus.cs & ~bus.rd_n;
    assign wr_act  = bus.cs & ~bus.wr_n;
    assign rd_stb  = rd_act & ~rd_q;
    assign wr_stb  = wr_act & ~wr_q;
    assign pop     = rd_stb & bus.rs & ~empty;
    assign flush   = wr_stb & ~bus.rs & bus.data_in[1];
    // a pop in the same cycle frees the slot the push needs
    assign push_ok = push_req & (~full | pop) & ~flush;

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[c_fifo_bits-1:0]] <= shift;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ovr     <= 1'b0;
            perr    <= 1'b0;
            ien     <= 1'b0;
            n_int_q <= 1'b1;
        end else begin
            rd_q    <= rd_act;
            wr_q    <= wr_act;
            n_int_q <= ~(ien & ~empty);
            if (push_ok)
                wr_ptr <= wr_ptr + ptr_one;
            if (flush)
                rd_ptr <= wr_ptr;
            else if (pop)
                rd_ptr <= rd_ptr + ptr_one;

            if (wr_stb && !bus.rs) begin
                ien <= bus.data_in[7];
                if (bus.data_in[0]) begin
                    ovr  <= 1'b0;
                    perr <= 1'b0;
                end
            end
            if (push_req && full && !pop && !flush)
                ovr <= 1'b1;
            if (frame_err)
                perr <= 1'b1;
        end
    end

    assign status = {ien, 3'b000, perr, ovr, full, ~empty};

    always_comb begin
        dout = 8'h00;
        if (rd_act) begin
            if (!bus.rs)
                dout = status;
            else if (!empty)
                dout = mem[rd_ptr[c_fifo_bits-1:0]];
        end
    end

    assign bus.data_out = dout;
    assign bus.n_int    = n_int_q;
endmodule

// File: tb/tb_ps2_kbd.sv
// Directed plus randomized bench for ps2_kbd; a queue-based model of the
// keyboard controller supplies every expected value.
module tb_ps2_kbd;
    logic clk = 1'b0;
    logic reset_n;
    logic ps2_clk;
    logic ps2_data;

    ps2_kbd_if bus ();

    ps2_kbd dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .bus      (bus.slave)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] m_q[$];
    bit m_ovr, m_perr, m_ien;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {m_ien, 3'b000, m_perr, m_ovr, m_q.size() == 8, m_q.size() != 0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        tick(5);
        @(negedge clk) ps2_clk = 1'b0;
        tick(10);
        @(negedge clk) ps2_clk = 1'b1;
        tick(5);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(fr[i]);
        tick(4);
    endtask

    task automatic send_model(input logic [7:0] b, input bit bad_par);
        send_frame(b, bad_par, 11);
        if (bad_par)
            m_perr = 1'b1;
        else if (m_q.size() == 8)
            m_ovr = 1'b1;
        else
            m_q.push_back(b);
    endtask

    task automatic cpu_read(input logic rs_v, output logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rs = rs_v; bus.rd_n = 1'b0;
        #2 d = bus.data_out;
        @(negedge clk);
        bus.cs = 1'b0; bus.rd_n = 1'b1;
    endtask

    task automatic cpu_write(input logic rs_v, input logic [7:0] d);
        @(negedge clk);
        bus.cs = 1'b1; bus.rs = rs_v; bus.wr_n = 1'b0; bus.data_in = d;
        @(negedge clk);
        bus.cs = 1'b0; bus.wr_n = 1'b1;
    endtask

    task automatic ctrl(input logic [7:0] d);
        cpu_write(1'b0, d);
        m_ien = d[7];
        if (d[0]) begin m_ovr = 1'b0; m_perr = 1'b0; end
        if (d[1]) m_q.delete();
    endtask

    task automatic chk_status(input string tag);
        logic [7:0] d;
        cpu_read(1'b0, d);
        check(tag, d, m_status());
    endtask

    task automatic chk_data(input string tag);
        logic [7:0] d, e;
        cpu_read(1'b1, d);
        e = (m_q.size() != 0) ? m_q.pop_front() : 8'h00;
        check(tag, d, e);
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        bit bad;

        reset_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1;
        bus.cs = 1'b0; bus.rs = 1'b0; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.data_in = 8'h00;
        m_ovr = 0; m_perr = 0; m_ien = 0;
        tick(3);
        @(negedge clk) reset_n = 1'b1;
        tick(2);
        @(negedge clk);
        check("reset_n_int", {7'd0, bus.n_int}, 8'h01);
        check("reset_dout_idle", bus.data_out, 8'h00);
        chk_status("reset_status");

        send_model(8'h1C, 1'b0);
        chk_status("single_status");
        chk_data("single_data");
        chk_status("single_status_after");

        ctrl(8'h80);
        send_model(8'hF0, 1'b0);
        check("int_low_after_push", {7'd0, bus.n_int}, 8'h00);
        chk_data("int_data");
        check("int_still_low_pop_cycle", {7'd0, bus.n_int}, 8'h00);
        @(negedge clk);
        check("int_high_after_pop", {7'd0, bus.n_int}, 8'h01);

        ctrl(8'h00);
        for (int i = 1; i <= 9; i++)
            send_model(8'(i), 1'b0);
        chk_status("full_ovr_status");
        for (int i = 0; i < 9; i++)
            chk_data("full_drain");
        ctrl(8'h01);
        chk_status("ovr_cleared");

        send_model(8'h5A, 1'b1);
        chk_status("perr_status");
        send_model(8'h5A, 1'b0);
        chk_data("after_perr_data");
        ctrl(8'h01);

        send_frame(8'h77, 1'b0, 4);
        tick(50001);
        send_model(8'h33, 1'b0);
        chk_status("timeout_status");
        chk_data("timeout_data");

        send_model(8'hA1, 1'b0);
        send_model(8'hB2, 1'b0);
        @(negedge clk);
        bus.cs = 1'b1; bus.rs = 1'b1; bus.rd_n = 1'b0;
        #2 d = bus.data_out;
        check("long_read_head", d, m_q.pop_front());
        repeat (10) @(negedge clk);
        bus.cs = 1'b0; bus.rd_n = 1'b1;
        chk_status("long_read_status");
        chk_data("long_read_next");

        send_model(8'h11, 1'b0);
        send_model(8'h22, 1'b0);
        cpu_write(1'b1, 8'hFF);
        chk_status("data_write_noeffect");
        ctrl(8'h02);
        chk_status("flush_status");
        chk_data("flush_empty_read");

        for (int i = 0; i < 20; i++) begin
            b = 8'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            send_model(b, bad);
            if ($urandom_range(0, 1) == 1)
                chk_data("rand_data");
            if ($urandom_range(0, 4) == 0)
                ctrl({1'($urandom), 6'd0, 1'($urandom)});
            chk_status("rand_status");
        end
        repeat (9) chk_data("rand_drain");
        chk_status("rand_final_status");

        ctrl(8'h80);
        send_model(8'h44, 1'b0);
        send_frame(8'hAA, 1'b0, 5);
        @(negedge clk) reset_n = 1'b0;
        tick(2);
        @(negedge clk) reset_n = 1'b1;
        m_q.delete(); m_ovr = 0; m_perr = 0; m_ien = 0;
        tick(2);
        @(negedge clk);
        check("midreset_n_int", {7'd0, bus.n_int}, 8'h01);
        chk_status("midreset_status");
        send_model(8'h3C, 1'b0);
        chk_data("midreset_fresh_frame");
        chk_status("midreset_final_status");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
